weighted_rr_arbiter: RTL

//  Parametrised N-way weighted round-robin arbiter; successor to the fixed 4-way roundrobin_arbiter.

---
 rtl/weighted_rr_arbiter.sv | 85 ++++++++
 1 files changed

// File: rtl/weighted_rr_arbiter.sv
// N-way weighted round-robin arbiter with per-requester lock.
// Registered one-hot grant, encoded index and valid; no combinational path from inputs to outputs.
module weighted_rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned WW = 3,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      REQ,
  input  logic [N-1:0]      LOCK,
  input  logic [N*WW-1:0]   WEIGHT,
  output logic [N-1:0]      GNT,
  output logic [IW-1:0]     GNT_IDX,
  output logic              GNT_VALID
);

  // One extra bit so ptr + offset can be reduced mod N without overflow.
  localparam int unsigned CW = IW + 1;

  logic [IW-1:0] ptr_q;
  logic [WW-1:0] cnt_q;

  logic [WW-1:0] own_weight;
  logic          own_req;
  logic          hold_lock;
  logic          hold_cnt;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] win_next_ptr;
  logic [CW-1:0] cand;
  logic [N-1:0]  win_onehot;

  always_comb begin
    own_weight = WEIGHT[GNT_IDX*WW +: WW];
    own_req    = GNT_VALID & REQ[GNT_IDX];
    hold_lock  = own_req & LOCK[GNT_IDX];
    hold_cnt   = own_req & (cnt_q < own_weight);
  end

  // Rotating priority search starting at ptr_q, unrolled into a single cycle.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + CW'(k);
      if (cand >= CW'(N)) begin
        cand = cand - CW'(N);
      end
      if (!win_found && REQ[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
    win_next_ptr = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
    win_onehot   = {{(N-1){1'b0}}, 1'b1} << win_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      GNT       <= '0;
      GNT_IDX   <= '0;
      GNT_VALID <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else if (hold_lock) begin
      cnt_q <= cnt_q;
    end else if (hold_cnt) begin
      cnt_q <= cnt_q + WW'(1);
    end else if (win_found) begin
      GNT       <= win_onehot;
      GNT_IDX   <= win_idx;
      GNT_VALID <= 1'b1;
      ptr_q     <= win_next_ptr;
      cnt_q     <= '0;
    end else begin
      GNT       <= '0;
      GNT_IDX   <= '0;
      GNT_VALID <= 1'b0;
      cnt_q     <= '0;
    end
  end

endmodule
